// File: rtl/psx_controller.sv
`default_nettype none
// ============================================================================
// Module   : psx_controller
// Purpose  : PlayStation digital pad emulator. Answers a host poll
//            (01 42 xx xx xx) with FF, DEVICE_ID, 5A and two button bytes,
//            pulsing ack low after each of the first four bytes.
// Ports    : clk          system clock
//            rst_n        asynchronous active-low reset
//            att          host attention, active-low, frames a transaction
//            psx_clk      host serial clock, idle high
//            cmd          host-to-pad serial data, LSB first
//            button_state pad buttons, active-low ([15:8] byte 3, [7:0] byte 4)
//            data         pad-to-host serial data, MSB first, idle high
//            ack          byte acknowledge, active-low pulse
// Revision : 1.0 - initial release
// ============================================================================
module psx_controller #(
  parameter logic [31:0] ACK_DELAY = 32'd20,
  parameter logic [31:0] ACK_WIDTH = 32'd4,
  parameter logic [7:0]  DEVICE_ID = 8'h41
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] button_state,
  output logic        data,
  output logic        ack
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_ACK_WAIT  = 3'd2,
    ST_ACK_PULSE = 3'd3,
    ST_IGNORE    = 3'd4
  } state_t;

  localparam logic [7:0] c_CMD_POLL  = 8'h01;
  localparam logic [7:0] c_CMD_READ  = 8'h42;
  localparam logic [2:0] c_LAST_BYTE = 3'd4;

  // Synchronizers and edge-detect history
  logic [1:0]  r_att_sync;
  logic [1:0]  r_clk_sync;
  logic [1:0]  r_cmd_sync;
  logic [1:0]  r_fill;      // marks when the synchronizers hold real samples
  logic        r_att_hi;    // att was genuinely seen high last cycle
  logic        r_clk_prev;

  // Transaction state
  state_t      r_state;
  logic [2:0]  r_byte;
  logic [2:0]  r_bit;
  logic [31:0] r_cnt;
  logic [6:0]  r_cmd_sh;    // command bits received so far, LSB first
  logic [6:0]  r_tx;        // remaining reply bits after the one on data
  logic        r_data;
  logic        r_ack;

  logic        w_att;
  logic        w_clk;
  logic        w_cmd;
  logic        w_clk_rise;
  logic        w_att_fall;
  logic [7:0]  w_cmd_byte;
  logic [32:0] w_cnt_next;
  logic [7:0]  w_next_reply;

  function automatic logic [7:0] reply_byte(input logic [2:0] idx,
                                            input logic [15:0] btn);
    logic [7:0] v;
    case (idx)
      3'd0:    v = 8'hFF;
      3'd1:    v = DEVICE_ID;
      3'd2:    v = 8'h5A;
      3'd3:    v = btn[15:8];
      3'd4:    v = btn[7:0];
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  assign w_att        = r_att_sync[1];
  assign w_clk        = r_clk_sync[1];
  assign w_cmd        = r_cmd_sync[1];
  assign w_clk_rise   = w_clk & ~r_clk_prev;
  // r_att_hi is only set from real samples, so an att already low when reset
  // releases can never look like a falling edge.
  assign w_att_fall   = r_att_hi & ~w_att;
  assign w_cmd_byte   = {w_cmd, r_cmd_sh};
  assign w_cnt_next   = {1'b0, r_cnt} + 33'd1;
  assign w_next_reply = reply_byte(r_byte + 3'd1, button_state);

  assign data = r_data;
  assign ack  = r_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_att_sync <= 2'b11;
      r_clk_sync <= 2'b11;
      r_cmd_sync <= 2'b11;
      r_fill     <= 2'b00;
      r_att_hi   <= 1'b0;
      r_clk_prev <= 1'b1;
      r_state    <= ST_IDLE;
      r_byte     <= 3'd0;
      r_bit      <= 3'd0;
      r_cnt      <= 32'd0;
      r_cmd_sh   <= 7'd0;
      r_tx       <= 7'h7F;
      r_data     <= 1'b1;
      r_ack      <= 1'b1;
    end else begin
      r_att_sync <= {r_att_sync[0], att};
      r_clk_sync <= {r_clk_sync[0], psx_clk};
      r_cmd_sync <= {r_cmd_sync[0], cmd};
      r_fill     <= {r_fill[0], 1'b1};
      r_att_hi   <= r_fill[1] & w_att;
      r_clk_prev <= w_clk;

      if (w_att) begin
        // Host released attention: abort whatever is in flight.
        r_state <= ST_IDLE;
        r_byte  <= 3'd0;
        r_bit   <= 3'd0;
        r_cnt   <= 32'd0;
        r_data  <= 1'b1;
        r_ack   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_data <= 1'b1;
            r_ack  <= 1'b1;
            if (w_att_fall) begin
              r_state  <= ST_SHIFT;
              r_byte   <= 3'd0;
              r_bit    <= 3'd0;
              r_cmd_sh <= 7'd0;
              r_tx     <= 7'h7F;   // reply byte 0 is FF
              r_data   <= 1'b1;
            end
          end

          ST_SHIFT: begin
            if (w_clk_rise) begin
              r_cmd_sh <= w_cmd_byte[7:1];
              r_tx     <= {r_tx[5:0], 1'b1};
              if (r_bit == 3'd7) begin
                r_data <= 1'b1;
                r_bit  <= 3'd0;
                if (r_byte == c_LAST_BYTE) begin
                  r_state <= ST_IGNORE;
                end else if ((r_byte == 3'd0 && w_cmd_byte != c_CMD_POLL) ||
                             (r_byte == 3'd1 && w_cmd_byte != c_CMD_READ)) begin
                  r_state <= ST_IGNORE;
                end else begin
                  r_state <= ST_ACK_WAIT;
                  r_cnt   <= 32'd0;
                end
              end else begin
                r_data <= r_tx[6];
                r_bit  <= r_bit + 3'd1;
              end
            end
          end

          // psx_clk edges are deliberately not looked at in the two ack states.
          ST_ACK_WAIT: begin
            if (w_cnt_next >= {1'b0, ACK_DELAY}) begin
              r_ack   <= 1'b0;
              r_cnt   <= 32'd0;
              r_state <= ST_ACK_PULSE;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          ST_ACK_PULSE: begin
            if (w_cnt_next >= {1'b0, ACK_WIDTH}) begin
              // Button bytes are captured here, at load time.
              r_ack   <= 1'b1;
              r_cnt   <= 32'd0;
              r_byte  <= r_byte + 3'd1;
              r_bit   <= 3'd0;
              r_tx    <= w_next_reply[6:0];
              r_data  <= w_next_reply[7];
              r_state <= ST_SHIFT;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end

          ST_IGNORE: begin
            r_data <= 1'b1;
            r_ack  <= 1'b1;
          end

          default: begin
            r_state <= ST_IDLE;
            r_data  <= 1'b1;
            r_ack   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psx_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_psx_controller
// Purpose  : Self-checking bench for psx_controller. Plays the PSX host role
//            (att / psx_clk / cmd) and compares received bytes and ack timing
//            against a transaction-level model of the pad reply.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psx_controller;

  localparam int         c_ACK_DELAY = 20;
  localparam int         c_ACK_WIDTH = 4;
  localparam logic [7:0] c_DEV_ID    = 8'h41;
  // psx_clk rise -> two synchronizer stages -> edge detect, then ACK_DELAY
  localparam int         c_ACK_LAT   = c_ACK_DELAY + 3;

  logic        clk;
  logic        rst_n;
  logic        att;
  logic        psx_clk;
  logic        cmd;
  logic [15:0] button_state;
  logic        data;
  logic        ack;

  int n_total;
  int n_bad;
  int cyc;
  int rise_cyc;

  psx_controller #(
    .ACK_DELAY (32'(c_ACK_DELAY)),
    .ACK_WIDTH (32'(c_ACK_WIDTH)),
    .DEVICE_ID (c_DEV_ID)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .att          (att),
    .psx_clk      (psx_clk),
    .cmd          (cmd),
    .button_state (button_state),
    .data         (data),
    .ack          (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One host byte: 4 clk low, 4 clk high per bit. The pad bit is read at the
  // end of each high phase, just before the next falling edge.
  task automatic xfer_byte(input logic [7:0] c, input int nbits,
                           input bit chg, input logic [15:0] new_btn,
                           output logic [7:0] r);
    r = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      r[7-i]  = data;
      psx_clk = 1'b0;
      cmd     = c[i];
      if (chg && i == 3) button_state = new_btn;
      repeat (4) @(negedge clk);
      psx_clk  = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_ack(input string tag, input bit expect_ack);
    int lows;
    int d;
    bit seen;
    if (expect_ack) begin
      seen = 1'b0;
      d    = 0;
      while (!seen && (cyc - rise_cyc) <= c_ACK_LAT + 40) begin
        @(negedge clk);
        if (ack === 1'b0) begin
          seen = 1'b1;
          d    = cyc - rise_cyc;
        end
      end
      check_val({tag, "_ack_seen"}, 32'(seen), 32'd1);
      if (seen) begin
        check_val({tag, "_ack_dly"}, d, c_ACK_LAT);
        lows = 1;
        while (ack === 1'b0 && lows < 40) begin
          @(negedge clk);
          if (ack === 1'b0) lows++;
        end
        check_val({tag, "_ack_w"}, lows, c_ACK_WIDTH);
      end
      repeat (3) @(negedge clk);
    end else begin
      lows = 0;
      repeat (c_ACK_LAT + 20) begin
        @(negedge clk);
        if (ack !== 1'b1) lows++;
      end
      check_val({tag, "_noack"}, lows, 0);
    end
  endtask

  // Full host poll. Reference: the pad answers FF, ID, 5A, buttons[15:8],
  // buttons[7:0] with buttons taken when each byte starts; a bad command
  // byte at 0 or 1 silences the pad (data high, no ack) until att rises.
  task automatic poll(input string tag, input logic [7:0] c0,
                      input logic [7:0] c1, input logic [15:0] btn,
                      input bit chg, input logic [15:0] btn2);
    logic [7:0]  exp_b [5];
    logic [7:0]  cb;
    logic [7:0]  rx;
    logic [15:0] btn_b4;
    bit          live;
    int          silent;
    btn_b4   = chg ? btn2 : btn;
    exp_b[0] = 8'hFF;
    exp_b[1] = c_DEV_ID;
    exp_b[2] = 8'h5A;
    exp_b[3] = btn[15:8];
    exp_b[4] = btn_b4[7:0];
    button_state = btn;
    live   = 1'b1;
    silent = 0;
    @(negedge clk);
    att = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 5 && silent < 2; k++) begin
      cb = (k == 0) ? c0 : (k == 1) ? c1 : 8'($urandom);
      xfer_byte(cb, 8, chg && k == 3, btn2, rx);
      check_val($sformatf("%s_b%0d", tag, k), rx, live ? exp_b[k] : 8'hFF);
      if (live) live = !((k == 0 && c0 != 8'h01) || (k == 1 && c1 != 8'h42));
      if (!live) silent++;
      wait_ack($sformatf("%s_b%0d", tag, k), live && k < 4);
    end
    att = 1'b1;
    repeat (8) @(negedge clk);
    check_val({tag, "_end_data"}, 32'(data), 32'd1);
    check_val({tag, "_end_ack"}, 32'(ack), 32'd1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx;
    logic [7:0]  rc0;
    logic [7:0]  rc1;
    int          guard;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rise_cyc = 0;
    rst_n   = 1'b0;
    att     = 1'b1;
    psx_clk = 1'b1;
    cmd     = 1'b1;
    button_state = 16'hFFFF;
    repeat (4) @(negedge clk);
    check_val("rst_data", 32'(data), 32'd1);
    check_val("rst_ack", 32'(ack), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("idle_data", 32'(data), 32'd1);
    check_val("idle_ack", 32'(ack), 32'd1);

    // Standard poll
    poll("std", 8'h01, 8'h42, 16'hFFFE, 1'b0, 16'h0);
    // Wrong first command, then a good poll
    poll("bad0", 8'h02, 8'h42, 16'h1234, 1'b0, 16'h0);
    poll("aft0", 8'h01, 8'h42, 16'hA55A, 1'b0, 16'h0);
    // Wrong second command
    poll("bad1", 8'h01, 8'h43, 16'h1234, 1'b0, 16'h0);
    // Buttons change during byte 3
    poll("chg", 8'h01, 8'h42, 16'hFFFF, 1'b1, 16'h0000);

    // Abort three bits into byte 3
    button_state = 16'h0000;
    att = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      xfer_byte((k == 0) ? 8'h01 : (k == 1) ? 8'h42 : 8'h00, 8, 1'b0, 16'h0, rx);
      wait_ack($sformatf("abt_b%0d", k), 1'b1);
    end
    xfer_byte(8'h00, 3, 1'b0, 16'h0, rx);
    check_val("abt_mid_data", 32'(data), 32'd0);
    att = 1'b1;
    repeat (3) @(negedge clk);
    check_val("abt_data", 32'(data), 32'd1);
    check_val("abt_ack", 32'(ack), 32'd1);
    repeat (4) @(negedge clk);
    poll("post_abt", 8'h01, 8'h42, 16'h3C96, 1'b0, 16'h0);

    // Reset in the middle of an ack pulse, att kept low across release
    att = 1'b0;
    repeat (6) @(negedge clk);
    xfer_byte(8'h01, 8, 1'b0, 16'h0, rx);
    guard = 0;
    while (ack !== 1'b0 && guard < c_ACK_LAT + 40) begin
      @(negedge clk);
      guard++;
    end
    check_val("rsta_pulse", 32'(ack), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rsta_ack", 32'(ack), 32'd1);
    check_val("rsta_data", 32'(data), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    xfer_byte(8'h01, 8, 1'b0, 16'h0, rx);
    check_val("rsta_silent", rx, 8'hFF);
    wait_ack("rsta", 1'b0);
    att = 1'b1;
    repeat (6) @(negedge clk);
    poll("post_rst", 8'h01, 8'h42, 16'h7E81, 1'b0, 16'h0);

    // Randomized back-to-back polls
    for (int p = 0; p < 8; p++) begin
      rc0 = 8'h01;
      rc1 = 8'h42;
      if ($urandom_range(0, 4) == 0) rc0 = 8'($urandom_range(2, 255));
      if ($urandom_range(0, 4) == 0) rc1 = 8'($urandom_range(67, 255));
      poll($sformatf("rnd%0d", p), rc0, rc1, 16'($urandom),
           1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
